// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode
//               seven-segment display. Snapshots one of four 32-bit debug
//               sources once per frame and walks its nibbles across the
//               digits, inserting dead time at the start of every slot.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   src0..src3  in   32-bit debug sources
//   src_sel     in   source select, sampled only at frame start
//   freeze      in   1 = keep the current snapshot at frame start
//   blank_lz    in   1 = blank leading-zero digits (digit 0 never blanked)
//   nibble      out  hex value for the shared segment decoder
//   digit_an    out  active-low digit enables (one-hot-low or all ones)
//   seg_blank   out  1 = segments forced off
//   frame_done  out  one-cycle pulse in the last cycle of a frame
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       src0,
  input  logic [31:0]       src1,
  input  logic [31:0]       src2,
  input  logic [31:0]       src3,
  input  logic [1:0]        src_sel,
  input  logic              freeze,
  input  logic              blank_lz,
  output logic [3:0]        nibble,
  output logic [DIGITS-1:0] digit_an,
  output logic              seg_blank,
  output logic              frame_done
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DIGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VISW = 4 * DIGITS;

  localparam logic [DIVW-1:0] c_div_last = DIVW'(SCAN_DIV - 1);
  localparam logic [DIVW-1:0] c_dead     = DIVW'(DEAD);
  localparam logic [DIGW-1:0] c_dig_last = DIGW'(DIGITS - 1);

  logic [DIVW-1:0] r_div;
  logic [DIGW-1:0] r_dig;
  logic [31:0]     r_snap;

  logic            w_div_wrap;
  logic            w_frame_start;
  logic [DIVW-1:0] w_div_nxt;
  logic [DIGW-1:0] w_dig_nxt;
  logic [31:0]     w_src;
  logic [31:0]     w_snap_nxt;
  logic [VISW-1:0] w_vis;
  logic [VISW-1:0] w_upper;
  logic            w_dead;
  logic            w_lz_blank;

  always_comb begin
    w_src = src0;
    case (src_sel)
      2'd0:    w_src = src0;
      2'd1:    w_src = src1;
      2'd2:    w_src = src2;
      default: w_src = src3;
    endcase
  end

  always_comb begin
    w_div_wrap    = (r_div == c_div_last);
    w_div_nxt     = w_div_wrap ? '0 : r_div + 1'b1;
    w_dig_nxt     = r_dig;
    if (w_div_wrap) begin
      w_dig_nxt = (r_dig == c_dig_last) ? '0 : r_dig + 1'b1;
    end
    w_frame_start = (r_div == '0) && (r_dig == '0);
    w_snap_nxt    = (w_frame_start && !freeze) ? w_src : r_snap;

    // Outputs are registered but must describe the cycle after the edge,
    // so they are decoded from next-state values. This is also what lets
    // the freshly loaded snapshot reach the first active cycle of digit 0.
    w_vis      = w_snap_nxt[VISW-1:0];
    w_dead     = (w_div_nxt < c_dead);
    w_upper    = w_vis >> {w_dig_nxt, 2'b00};
    w_lz_blank = blank_lz && (w_dig_nxt != '0) && (w_upper == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_dig      <= '0;
      r_snap     <= '0;
      digit_an   <= '1;
      nibble     <= 4'h0;
      seg_blank  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_dig  <= w_dig_nxt;
      r_snap <= w_snap_nxt;
      if (w_dead) begin
        // Anti-ghosting gap: all anodes off, nibble keeps its last value.
        digit_an  <= '1;
        seg_blank <= 1'b1;
      end else begin
        digit_an  <= ~(DIGITS'(1) << w_dig_nxt);
        nibble    <= w_vis[{w_dig_nxt, 2'b00} +: 4];
        seg_blank <= w_lz_blank;
      end
      frame_done <= (w_dig_nxt == c_dig_last) && (w_div_nxt == c_div_last);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (DIGITS=8, SCAN_DIV=4,
//               DEAD=1). A time-based reference model pushes the expected
//               outputs for each cycle; they are popped and compared on the
//               following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int DEAD     = 1;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] nib;
    logic       bl;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src0, src1, src2, src3;
  logic [1:0]  src_sel;
  logic        freeze;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [7:0]  digit_an;
  logic        seg_blank;
  logic        frame_done;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model state
  int          m_t   = 0;
  logic [31:0] m_snap = '0;
  logic [3:0]  m_nib  = '0;

  seg_scan_ctrl #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .DEAD    (DEAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src0      (src0),
    .src1      (src1),
    .src2      (src2),
    .src3      (src3),
    .src_sel   (src_sel),
    .freeze    (freeze),
    .blank_lz  (blank_lz),
    .nibble    (nibble),
    .digit_an  (digit_an),
    .seg_blank (seg_blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", tag, got, exp, m_t, $time);
    end
  endtask

  function automatic logic [31:0] sel_src(input logic [1:0] s);
    case (s)
      2'd0:    return src0;
      2'd1:    return src1;
      2'd2:    return src2;
      default: return src3;
    endcase
  endfunction

  // Model: m_t is the index of the cycle following the edge, counted from
  // the first frame-start cycle after reset. Slot and phase derive from it.
  always @(posedge clk) begin
    exp_t e;
    int   pos, slot;
    if (!rst_n) begin
      m_t    = 0;
      m_snap = '0;
      m_nib  = '0;
    end else begin
      if ((m_t % FRAME) == 0 && !freeze) m_snap = sel_src(src_sel);
      m_t++;
    end
    pos  = m_t % SCAN_DIV;
    slot = (m_t / SCAN_DIV) % DIGITS;
    if (pos < DEAD) begin
      e.an = 8'hFF;
      e.bl = 1'b1;
    end else begin
      e.an  = ~(8'h01 << slot);
      m_nib = 4'((m_snap >> (4 * slot)) & 32'hF);
      e.bl  = blank_lz && (slot != 0) && ((m_snap >> (4 * slot)) == 32'h0);
    end
    e.nib = m_nib;
    e.fd  = ((m_t % FRAME) == FRAME - 1);
    if (!rst_n) begin
      e.an  = 8'hFF;
      e.nib = 4'h0;
      e.bl  = 1'b1;
      e.fd  = 1'b0;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("digit_an",   32'(digit_an),   32'(e.an));
      chk("nibble",     32'(nibble),     32'(e.nib));
      chk("seg_blank",  32'(seg_blank),  32'(e.bl));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the model says the next cycle sits at a given
  // offset within the frame.
  task automatic align(input int frame_pos);
    logic found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (((m_t + 1) % FRAME) == frame_pos) found = 1'b1;
    end
    chk("align", 32'(found), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    src0     = 32'h1234ABCD;
    src1     = $urandom;
    src2     = $urandom;
    src3     = $urandom;
    src_sel  = 2'd0;
    freeze   = 1'b0;
    blank_lz = 1'b0;

    // Reset held with random control inputs
    for (int i = 0; i < 3; i++) begin
      src_sel  = 2'($urandom_range(0, 3));
      freeze   = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      src1     = $urandom;
      cyc(1);
    end
    src_sel  = 2'd0;
    freeze   = 1'b0;
    blank_lz = 1'b0;
    rst_n    = 1'b1;

    // Scan order over two frames
    cyc(2 * FRAME);

    // Leading-zero blanking
    blank_lz = 1'b1;
    src0     = 32'h000000A0;
    cyc(2 * FRAME);
    src0     = 32'h00000000;
    cyc(2 * FRAME);
    src0     = 32'h0F000300;
    cyc(2 * FRAME);
    blank_lz = 1'b0;
    src0     = 32'h1234ABCD;
    cyc(2 * FRAME);

    // Freeze mid-frame, then change the source
    align(13);
    freeze = 1'b1;
    cyc(3);
    src0 = 32'hDEADBEEF;
    cyc(3 * FRAME);
    align(9);
    freeze = 1'b0;
    cyc(3 * FRAME);

    // Select change mid-frame (slot 3)
    src0 = 32'h1234ABCD;
    src2 = 32'h89ABCDEF;
    cyc(FRAME);
    align(3 * SCAN_DIV);
    src_sel = 2'd2;
    cyc(2 * FRAME);

    // Reset pulse at slot 5
    src_sel = 2'd1;
    src1    = 32'h0BADF00D;
    align(5 * SCAN_DIV + 2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2 * FRAME);

    cyc(1);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display in the MIPS pipeline debug path. Selects one of four 32-bit debug sources (PC, instruction, ALU result, write-back data). Snapshots that source once per frame and walks its nibbles across the digits, one at a time. Drives a single shared `s_seg` decoder through `nibble`. The top level forces all segments off while `seg_blank` is high.

## Interface

- `DIGITS`, 8, digit count; nibbles shown = DIGITS, max 8.
- `SCAN_DIV`, 50000, clock cycles per digit slot; must be ≥ 2.
- `DEAD`, 2, all-digits-off cycles at the start of each slot (anti-ghosting); 1 ≤ DEAD < SCAN_DIV.

- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `src0`..`src3` in 32 each: debug sources.
- `src_sel` in 2: source select; sampled only at frame start.
- `freeze` in 1: 1 = skip snapshot reload and hold the displayed value.
- `blank_lz` in 1: 1 = blank leading-zero digits.
- `nibble` out 4: hex value to the `s_seg` decoder.
- `digit_an` out DIGITS: digit enables, active-low, one-hot-low or all ones.
- `seg_blank` out 1: 1 = segments forced off.
- `frame_done` out 1: one-cycle pulse at frame end.

## Operation

- Divider `div` counts 0..SCAN_DIV-1, then wraps to 0. The width is ceil(log2(SCAN_DIV)).
- Digit index `dig` is 0..DIGITS-1. It increments when `div` wraps, and goes from DIGITS-1 back to 0.
- Frame start is the cycle with `dig`==0 and `div`==0.
  - In that cycle, if `freeze`==0, `snap` ← `src[src_sel]` on the next edge.
  - If `freeze`==1, `snap` is held.
- Changes to `src_sel` or the sources mid-frame never affect the current frame.
- Dead-time, while `div` < DEAD:
  - `digit_an` = all ones.
  - `seg_blank` = 1.
  - `nibble` holds its last value.
- Active window, while `div` ≥ DEAD:
  - `digit_an` bit `dig` = 0; all other bits = 1.
  - `nibble` = `snap[4*dig+3 : 4*dig]`.
- Leading-zero blanking:
  - Digit d is blanked when `blank_lz`==1, d ≠ 0, and `snap[4*DIGITS-1 : 4*d]` == 0.
  - In a blanked slot, `seg_blank` = 1 and `digit_an` still follows the active pattern.
  - Digit 0 is never blanked.
  - In all other active slots, `seg_blank` = 0.
- `frame_done` = 1 for exactly the cycle with `dig`==DIGITS-1 and `div`==SCAN_DIV-1.
- Reset (`rst_n`==0 at an edge), with all outputs registered:
  - State: `div`=0, `dig`=0, `snap`=0.
  - Outputs: `digit_an`=all ones, `nibble`=0, `seg_blank`=1, `frame_done`=0.
- Reset mid-slot or mid-frame aborts the scan. The first cycle after release is a frame start, so `snap` loads then.

## Timing

- All outputs are registered. `digit_an`, `nibble`, and `seg_blank` change on the edge where `div` becomes DEAD, or becomes 0 for the dead-time.
- The snapshot loads on the edge that ends frame-start cycle 0, so `snap` is stable from `div`==1. DEAD ≥ 1 guarantees the first displayed nibble already comes from the new snapshot.
- Slot length is SCAN_DIV cycles; frame length is DIGITS·SCAN_DIV cycles. Digit d is lit for SCAN_DIV-DEAD cycles per frame.
- Source-to-display latency is at most one frame plus DEAD+1 cycles.
- A `freeze` transition takes effect at the next frame start only.

## Test plan

Bench configuration for all scenarios: DIGITS=8, SCAN_DIV=4, DEAD=1.

1. Reset: hold `rst_n`=0 for 3 cycles with random inputs.
   - Expect `digit_an`=8'hFF, `nibble`=0, `seg_blank`=1, `frame_done`=0.
   - After release, expect `digit_an`=8'hFE with `nibble`=4'hD (for `src0`=32'h1234ABCD) at cycle 1 after release.
2. Scan order: `src_sel`=0, `src0`=32'h1234ABCD.
   - Slots 0..7 show `nibble` D,C,B,A,4,3,2,1, with `digit_an` FE,FD,FB,F7,EF,DF,BF,7F.
   - Each slot's cycle 0 shows FF.
   - `frame_done` pulses every 32 cycles.
3. Blanking: `blank_lz`=1.
   - With `src`=32'h000000A0: digits 0 and 1 show 0 and A with `seg_blank`=0; digits 2..7 have `seg_blank`=1.
   - With `src`=0: only digit 0 is unblanked, showing 0.
4. Freeze: assert `freeze` mid-frame, then change `src0` to 32'hDEADBEEF.
   - The old value stays on every subsequent frame.
   - Deassert `freeze`: the new value appears starting the frame after the next frame start.
5. Select change mid-frame: switch `src_sel` 0→2 at slot 3.
   - Slots 3..7 still show `src0` nibbles.
   - The next frame shows `src2`.
6. Reset mid-frame: drop `rst_n` for 1 cycle at slot 5.
   - All outputs take reset values on the next edge.
   - The scan restarts at digit 0 with a fresh snapshot.
